// File: rtl/seed_block_unloader.sv
// Captures a finished 128-bit SEED block and streams it out as 32-bit words, most-significant word first.
// Latency: capture is 1 cycle from blk_valid to dout_valid; then 1 word/cycle while dout_ready is held high.
// Backpressure: dout stays held while dout_ready is low; blk_valid pulses that arrive while busy are dropped and flagged in overrun.
module seed_block_unloader #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      blk_valid,
  input  logic [WORD_W*WORDS-1:0]   blk_data,
  output logic                      sync,
  output logic [WORD_W-1:0]         dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_last,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      clr_ovr
);

  localparam int BLK_W = WORD_W * WORDS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BLK_W-1:0]   shreg;
  logic [BLK_W-1:0]   shreg_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               ovr_nxt;

  // State register; clk_en low freezes the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  // Shift register, word counter and sticky overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else if (clk_en) begin
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      overrun <= ovr_nxt;
    end
  end

  // Next-state logic: capture in IDLE, shift out on each handshake in SEND.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    ovr_nxt   = overrun;

    // Set wins over clear when both land on the same edge.
    if (clr_ovr) begin
      ovr_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (blk_valid) begin
          shreg_nxt = blk_data;
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        // A new block cannot be taken until the current one has fully drained,
        // including the last-word handshake edge itself.
        if (blk_valid) begin
          ovr_nxt = 1'b1;
        end
        if (dout_ready) begin
          if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
          end else begin
            shreg_nxt = shreg << WORD_W;
            cnt_nxt   = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registers, so dout_ready has no path to any output.
  assign dout       = shreg[BLK_W-1 -: WORD_W];
  assign sync       = (state == SEND);
  assign busy       = (state == SEND);
  assign dout_valid = (state == SEND);
  assign dout_last  = (state == SEND) && (cnt == CNT_LAST);

endmodule

// File: tb/tb_seed_block_unloader.sv
// Directed bench for seed_block_unloader with a queue-based reference model.
// Inputs change 2 time units after each rising edge; outputs are compared on falling edges.
// Literal expectations from hand-worked scenarios pin the model.
module tb_seed_block_unloader;

  localparam int WW = 32;
  localparam int NW = 4;

  logic          clk;
  logic          reset;
  logic          clk_en;
  logic          blk_valid;
  logic [127:0]  blk_data;
  logic          sync;
  logic [31:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          busy;
  logic          overrun;
  logic          clr_ovr;

  seed_block_unloader #(.WORD_W(WW), .WORDS(NW)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Reference model: a block is a queue of pending words, MS word first.
  bit          m_busy;
  bit          m_ovr;
  bit          m_zero;
  logic [31:0] m_q[$];
  logic [31:0] m_dummy;
  bit          m_was_busy;

  initial begin
    m_busy = 0;
    m_ovr  = 0;
    m_zero = 1;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_busy = 0;
        m_ovr  = 0;
        m_zero = 1;
        m_q.delete();
      end else if (clk_en) begin
        m_was_busy = m_busy;
        if (clr_ovr) m_ovr = 0;
        if (m_was_busy && blk_valid) m_ovr = 1;
        if (!m_was_busy) begin
          if (blk_valid) begin
            m_q.delete();
            for (int i = NW - 1; i >= 0; i--) m_q.push_back(blk_data[i*WW +: WW]);
            m_busy = 1;
            m_zero = 0;
          end
        end else if (dout_ready) begin
          m_dummy = m_q.pop_front();
          if (m_q.size() == 0) m_busy = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted words.
  logic [31:0] got_w[$];
  bit          got_l[$];
  int          sync_hi;

  initial begin
    sync_hi = 0;
    forever begin
      @(negedge clk);
      chk1("sync", sync, m_busy);
      chk1("dout_valid", dout_valid, m_busy);
      chk1("busy", busy, m_busy);
      chk1("dout_last", dout_last, m_busy && (m_q.size() == 1));
      chk1("overrun", overrun, m_ovr);
      if (m_busy) chk("dout", dout, m_q[0]);
      else if (m_zero) chk("dout_zero", dout, 32'h0);
      if (sync) sync_hi++;
      if (reset && clk_en && dout_valid && dout_ready) begin
        got_w.push_back(dout);
        got_l.push_back(dout_last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_pulse(input logic [127:0] d);
    blk_data  = d;
    blk_valid = 1'b1;
    step(1);
    blk_valid = 1'b0;
  endtask

  task automatic clear_log();
    got_w.delete();
    got_l.delete();
    sync_hi = 0;
  endtask

  task automatic chk_got(input string name, input int base, input int total,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] e[4];
    e[0] = w0; e[1] = w1; e[2] = w2; e[3] = w3;
    chk($sformatf("%s_count", name), 32'(got_w.size()), 32'(total));
    if (got_w.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_w%0d", name, i), got_w[base+i], e[i]);
        chk1($sformatf("%s_last%0d", name, i), got_l[base+i], (i == 3));
      end
    end
  endtask

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] BLK_F = {128{1'b1}};

  initial begin
    reset      = 1'b0;
    clk_en     = 1'b1;
    blk_valid  = 1'b0;
    blk_data   = '0;
    dout_ready = 1'b0;
    clr_ovr    = 1'b0;
    step(3);
    chk1("rst_sync", sync, 1'b0);
    chk1("rst_valid", dout_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_last", dout_last, 1'b0);
    chk1("rst_ovr", overrun, 1'b0);
    chk("rst_dout", dout, 32'h0);
    reset = 1'b1;
    step(2);

    // Basic transfer
    dout_ready = 1'b1;
    clear_log();
    send_pulse(BLK_A);
    step(6);
    chk_got("basic", 0, 4, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    chk("basic_sync_cycles", 32'(sync_hi), 32'd4);

    // Backpressure before word 2
    clear_log();
    send_pulse(BLK_A);
    step(2);
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_dout", dout, 32'h8899AABB);
      chk1("bp_hold_valid", dout_valid, 1'b1);
      step(1);
    end
    dout_ready = 1'b1;
    step(6);
    chk_got("bp", 0, 4, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    chk("bp_sync_cycles", 32'(sync_hi), 32'd7);

    // Overrun during word 1, then clear
    clear_log();
    send_pulse(BLK_A);
    step(1);
    blk_data  = BLK_F;
    blk_valid = 1'b1;
    step(1);
    blk_valid = 1'b0;
    blk_data  = BLK_A;
    chk1("ovr_set", overrun, 1'b1);
    step(6);
    chk1("ovr_sticky", overrun, 1'b1);
    chk_got("ovr", 0, 4, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    chk1("ovr_clr", overrun, 1'b0);

    // Clock enable gap with a stray block pulse
    clear_log();
    send_pulse(BLK_A);
    step(1);
    clk_en = 1'b0;
    step(1);
    blk_data  = BLK_F;
    blk_valid = 1'b1;
    step(1);
    blk_valid = 1'b0;
    blk_data  = BLK_A;
    step(3);
    chk("ce_words_in_gap", 32'(got_w.size()), 32'd1);
    chk("ce_hold_dout", dout, 32'h44556677);
    chk1("ce_hold_valid", dout_valid, 1'b1);
    clk_en = 1'b1;
    step(6);
    chk_got("ce", 0, 4, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    chk1("ce_no_ovr", overrun, 1'b0);

    // Asynchronous reset mid-block
    clear_log();
    send_pulse(BLK_A);
    step(2);
    #1 reset = 1'b0;
    #1;
    chk1("arst_sync", sync, 1'b0);
    chk1("arst_valid", dout_valid, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_last", dout_last, 1'b0);
    chk("arst_dout", dout, 32'h0);
    step(2);
    reset = 1'b1;
    step(1);
    clear_log();
    send_pulse(128'h1);
    step(6);
    chk_got("post_rst", 0, 4, 32'h0, 32'h0, 32'h0, 32'h00000001);

    // Back-to-back blocks
    clear_log();
    send_pulse(BLK_A);
    step(4);
    chk1("b2b_gap_sync", sync, 1'b0);
    send_pulse(BLK_B);
    chk1("b2b_resync", sync, 1'b1);
    chk1("b2b_no_ovr", overrun, 1'b0);
    step(6);
    chk_got("b2b_a", 0, 8, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    chk_got("b2b_b", 4, 8, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0);
    chk("b2b_sync_cycles", 32'(sync_hi), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
